// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
//
// Purpose:
//   Multi-cycle WIDTH-bit adder/subtractor. It reuses a single 4-bit
//   carry-lookahead slice, which is stepped across the operands one nibble
//   per clock, least significant nibble first. A carry register links the
//   nibbles, so the carry ripples across all steps. This trades latency
//   (NIBBLES cycles) for a much smaller adder than a full-width lookahead
//   design.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand request valid
//   in_ready_o   block can accept a request (high only in IDLE)
//   a_i          operand A
//   b_i          operand B
//   cin_i        carry-in for add; ignored when sub_i=1
//   sub_i        1 selects A-B, 0 selects A+B+cin
//   out_valid_o  result available (high only in DONE)
//   out_ready_i  consumer takes the result
//   sum_o        result
//   cout_o       carry out of the MSB; for subtract, 1 means no borrow
//   ovf_o        two's-complement signed overflow
//
// Every output is either a register or a decode of the state register,
// so there is no combinational path from in_valid_i/out_ready_i to an output.
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead slice. All internal carries are formed directly from
// the generate/propagate terms and the slice carry-in, with no rippling
// inside the slice.
module cla4_slice (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c4_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = x_i ^ y_i;
  assign g = x_i & y_i;

  assign c1 = g[0]
            | (p[0] & c_i);

  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & c_i);

  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c_i);

  assign c4_o = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ {c3, c2, c1, c_i};

endmodule


module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NIBBLES = WIDTH / 4;
  // A single-nibble configuration still needs a 1-bit index register.
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  a_d;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  b_d;
  logic              carry_q;
  logic              carry_d;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   idx_d;
  logic [WIDTH-1:0]  work_q;
  logic [WIDTH-1:0]  work_d;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_q;
  logic              cout_d;
  logic              ovf_q;
  logic              ovf_d;

  logic [3:0]        slice_x;
  logic [3:0]        slice_y;
  logic [3:0]        slice_s;
  logic              slice_c4;
  logic [WIDTH-1:0]  work_merged;
  logic              last_nibble;

  assign last_nibble = (idx_q == IDXW'(NIBBLES - 1));

  // ---------------------------------------------------------------------------
  // Slice operand selection and result merge
  // ---------------------------------------------------------------------------

  // Pick the current nibble of each operand. A compare-per-nibble mux is used
  // instead of a variable part-select so the index width never has to match
  // the bit-offset arithmetic.
  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDXW'(n)) begin
        slice_x = a_q[4*n +: 4];
        slice_y = b_q[4*n +: 4];
      end
    end
  end

  cla4_slice u_slice (
    .x_i  (slice_x),
    .y_i  (slice_y),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .c4_o (slice_c4)
  );

  // Working result with the current slice sum written into nibble idx. On the
  // last step this is the complete result that is loaded into sum_q.
  always_comb begin
    work_merged = work_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDXW'(n)) begin
        work_merged[4*n +: 4] = slice_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Subtraction is A + ~B + 1: B is inverted when it is captured and the carry
  // register is seeded with 1, so the slice itself only ever adds.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i | cin_i;
          idx_d   = '0;
        end
      end
      RUN: begin
        work_d  = work_merged;
        carry_d = slice_c4;
        if (last_nibble) begin
          idx_d  = '0;
          sum_d  = work_merged;
          cout_d = slice_c4;
          // Overflow: operands agree in sign but the result does not. b_q is
          // already inverted for subtract, which is the operand really added.
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 & (work_merged[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_adder
//
// Purpose:
//   Self-checking bench for cla_serial_adder at WIDTH=16. A table of directed
//   add/subtract vectors with hand-computed results is run through the full
//   handshake, followed by hand-written back-pressure and mid-operation reset
//   sequences. Inputs are driven 1 time unit after a rising edge and outputs
//   are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_cla_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int nChecks = 0;
  int nFails  = 0;

  // Last completed result; sum/cout/ovf must hold this until the next completion.
  logic [WIDTH-1:0] prevSum  = '0;
  logic             prevCout = 1'b0;
  logic             prevOvf  = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOvf;
    string       name;
  } vec_t;

  vec_t vecs[11];

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, then scramble the inputs
  // so any late sampling of a/b/cin/sub by the DUT corrupts the result.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic c, input logic s);
    int k;
    k = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = c;
    sub = s;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    checkOutput("accept_wait", 32'(k < 50), 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    cin = ~c;
    sub = ~s;
    checkOutput("in_ready_drop", 32'(in_ready), 32'd0);
  endtask

  // Called right after the accepting edge: counts edges until out_valid,
  // checking that the previous result is held meanwhile.
  task automatic waitResult(input string name, input logic [15:0] es,
                            input logic ec, input logic eo);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checkOutput({name, "_hold"}, {15'd0, cout, ovf, sum}, {15'd0, prevCout, prevOvf, prevSum});
      tick();
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd4);
    checkOutput({name, "_sum"}, 32'(sum), 32'(es));
    checkOutput({name, "_cout"}, 32'(cout), 32'(ec));
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(eo));
    prevSum  = es;
    prevCout = ec;
    prevOvf  = eo;
  endtask

  // With out_ready high, the next edge completes the handshake.
  task automatic finishHandshake(input string name);
    tick();
    checkOutput({name, "_out_valid_fall"}, 32'(out_valid), 32'd0);
    checkOutput({name, "_in_ready_rise"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_retain"}, {15'd0, cout, ovf, sum}, {15'd0, prevCout, prevOvf, prevSum});
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic"};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_all"};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "cin_only"};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
    vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
    vecs[6]  = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "alt_ripple"};
    vecs[7]  = '{16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal"};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf"};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_to_neg"};
    vecs[10] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf"};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_results", {15'd0, cout, ovf, sum}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Table-driven vectors with out_ready held high
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitResult(vecs[i].name, vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
      finishHandshake(vecs[i].name);
    end

    // Back-pressure: result must stay put and a competing request is refused
    out_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    waitResult("bp", 16'h3333, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 16'h0100;
    b = 16'h0200;
    cin = 1'b0;
    sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_stable", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b0, 16'h3333});
      tick();
    end
    out_ready = 1'b1;
    finishHandshake("bp");
    tick();
    checkOutput("bp_pending_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    waitResult("bp_pending", 16'h0300, 1'b0, 1'b0);
    finishHandshake("bp_pending");

    // Reset in the middle of RUN aborts the operation
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_results", {15'd0, cout, ovf, sum}, 32'd0);
    prevSum  = '0;
    prevCout = 1'b0;
    prevOvf  = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    waitResult("after_rst", 16'h0002, 1'b0, 1'b0);
    finishHandshake("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
